// File: rtl/hsci_align_pkg.sv
// Shared types and helpers for the HSCI MISO word aligner.
package hsci_align_pkg;

  // Alignment FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_t;

  // Training byte sent by the device, MSB first on the wire.
  localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'h5A;

  // Byte starting k bits into the 16-bit window, i.e. window[15-k -: 8].
  function automatic logic [7:0] window_slice(input logic [15:0] window, input logic [2:0] k);
    logic [15:0] shifted;
    shifted = window << k;
    return shifted[15:8];
  endfunction

  // Bit k of the result is set when the slice at offset k equals the pattern.
  function automatic logic [7:0] rot_match(input logic [15:0] window, input logic [7:0] pattern);
    logic [7:0] m;
    m = 8'd0;
    for (int k = 0; k < 8; k++) begin
      m[k] = (window_slice(window, k[2:0]) == pattern);
    end
    return m;
  endfunction

endpackage

// File: rtl/hsci_offset_detect.sv
// Combinational 8-way training-pattern comparator with a lowest-offset
// priority encoder.
module hsci_offset_detect
  import hsci_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN
) (
  input  logic [15:0] window,
  output logic        match_any,
  output logic [7:0]  match_vec,
  output logic [2:0]  first_k
);

  // Compare all offsets at once and pick the lowest matching one.
  always_comb begin
    match_vec = rot_match(window, TRAIN_PATTERN);
    match_any = |match_vec;
    casez (match_vec)
      8'b???????1: first_k = 3'd0;
      8'b??????10: first_k = 3'd1;
      8'b?????100: first_k = 3'd2;
      8'b????1000: first_k = 3'd3;
      8'b???10000: first_k = 3'd4;
      8'b??100000: first_k = 3'd5;
      8'b?1000000: first_k = 3'd6;
      8'b10000000: first_k = 3'd7;
      default:     first_k = 3'd0;
    endcase
  end

endmodule

// File: rtl/hsci_miso_word_aligner.sv
// HSCI MISO receive word aligner: finds the byte boundary in the PHY's
// unaligned 8-bit words using a repeating training byte, then emits
// byte-aligned data with one cycle of latency.
module hsci_miso_word_aligner
  import hsci_align_pkg::*;
#(
  parameter logic [7:0]  TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic       hsci_pclk,
  input  logic       hsci_rst,
  input  logic       enable,
  input  logic       realign,
  input  logic [7:0] raw_data,
  input  logic       raw_valid,
  output logic [7:0] aligned_data,
  output logic       aligned_valid,
  output logic       locked,
  output logic [2:0] bit_offset,
  output logic       align_timeout
);

  localparam logic [7:0]  LOCK_CNT_L = 8'(LOCK_COUNT);
  localparam logic [15:0] TO_LAST_L  = 16'(TIMEOUT - 1);

  align_state_t state_r;
  logic [7:0]   prev_r;
  logic [7:0]   match_cnt_r;
  logic [15:0]  to_cnt_r;

  logic [15:0]  window_s;
  logic         match_any_s;
  logic [7:0]   match_vec_s;
  logic [2:0]   first_k_s;
  logic         offset_match_s;

  assign window_s = {prev_r, raw_data};

  hsci_offset_detect #(
    .TRAIN_PATTERN (TRAIN_PATTERN)
  ) u_detect (
    .window    (window_s),
    .match_any (match_any_s),
    .match_vec (match_vec_s),
    .first_k   (first_k_s)
  );

  // Does the current window still match at the latched offset.
  always_comb begin
    offset_match_s = match_vec_s[bit_offset];
  end

  // Alignment FSM with window history, timeout counter and registered outputs.
  always_ff @(posedge hsci_pclk) begin
    if (hsci_rst) begin
      state_r       <= ST_IDLE;
      prev_r        <= 8'd0;
      match_cnt_r   <= 8'd0;
      to_cnt_r      <= 16'd0;
      aligned_data  <= 8'd0;
      aligned_valid <= 1'b0;
      locked        <= 1'b0;
      bit_offset    <= 3'd0;
      align_timeout <= 1'b0;
    end else begin
      // History is taken on every accepted word, even one discarded by realign.
      if (raw_valid) begin
        prev_r <= raw_data;
      end

      // Time spent hunting for lock, counted every cycle; align_timeout is sticky.
      if ((state_r == ST_SEARCH) || (state_r == ST_VERIFY)) begin
        if (to_cnt_r == TO_LAST_L) begin
          to_cnt_r      <= 16'd0;
          align_timeout <= 1'b1;
        end else begin
          to_cnt_r <= to_cnt_r + 16'd1;
        end
      end else begin
        to_cnt_r <= 16'd0;
      end

      aligned_valid <= 1'b0;

      if (!enable) begin
        state_r     <= ST_IDLE;
        locked      <= 1'b0;
        match_cnt_r <= 8'd0;
      end else if (realign && (state_r != ST_IDLE)) begin
        // bit_offset is left alone until the next match replaces it.
        state_r     <= ST_SEARCH;
        locked      <= 1'b0;
        match_cnt_r <= 8'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_SEARCH;
          end
          ST_SEARCH: begin
            if (raw_valid && match_any_s) begin
              bit_offset  <= first_k_s;
              match_cnt_r <= 8'd1;
              if (LOCK_CNT_L == 8'd1) begin
                state_r  <= ST_LOCKED;
                locked   <= 1'b1;
                to_cnt_r <= 16'd0;
              end else begin
                state_r <= ST_VERIFY;
              end
            end
          end
          ST_VERIFY: begin
            if (raw_valid) begin
              if (offset_match_s) begin
                match_cnt_r <= match_cnt_r + 8'd1;
                if ((match_cnt_r + 8'd1) == LOCK_CNT_L) begin
                  state_r  <= ST_LOCKED;
                  locked   <= 1'b1;
                  to_cnt_r <= 16'd0;
                end
              end else begin
                state_r     <= ST_SEARCH;
                match_cnt_r <= 8'd0;
              end
            end
          end
          ST_LOCKED: begin
            // Pass-through only; the pattern is no longer checked once locked.
            if (raw_valid) begin
              aligned_data  <= window_slice(window_s, bit_offset);
              aligned_valid <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hsci_miso_word_aligner.sv
// Self-checking bench for hsci_miso_word_aligner: per-cycle expectations are
// queued as stimulus is driven and compared one cycle later.
module tb_hsci_miso_word_aligner;

  logic       hsci_pclk = 1'b0;
  logic       hsci_rst;
  logic       enable;
  logic       realign;
  logic [7:0] raw_data;
  logic       raw_valid;
  logic [7:0] aligned_data;
  logic       aligned_valid;
  logic       locked;
  logic [2:0] bit_offset;
  logic       align_timeout;

  always #5 hsci_pclk = ~hsci_pclk;

  hsci_miso_word_aligner #(
    .TRAIN_PATTERN (8'h5A),
    .LOCK_COUNT    (16),
    .TIMEOUT       (64)
  ) dut (
    .hsci_pclk     (hsci_pclk),
    .hsci_rst      (hsci_rst),
    .enable        (enable),
    .realign       (realign),
    .raw_data      (raw_data),
    .raw_valid     (raw_valid),
    .aligned_data  (aligned_data),
    .aligned_valid (aligned_valid),
    .locked        (locked),
    .bit_offset    (bit_offset),
    .align_timeout (align_timeout)
  );

  typedef struct {
    logic       lk;
    logic       av;
    logic       chk_ad;
    logic [7:0] ad;
    logic       chk_off;
    logic [2:0] off;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic lk, input logic av, input logic chk_ad,
                              input logic [7:0] ad, input logic chk_off,
                              input logic [2:0] off, input logic to);
    exp_t e;
    e.lk = lk; e.av = av; e.chk_ad = chk_ad; e.ad = ad;
    e.chk_off = chk_off; e.off = off; e.to = to;
    return e;
  endfunction

  // Compare DUT outputs just after each edge against the queued expectation.
  always @(posedge hsci_pclk) begin : monitor
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("locked", locked, e.lk);
      check_val("aligned_valid", aligned_valid, e.av);
      check_val("align_timeout", align_timeout, e.to);
      if (e.chk_ad) check_val("aligned_data", aligned_data, e.ad);
      if (e.chk_off) check_val("bit_offset", bit_offset, e.off);
    end
  end

  task automatic drive(input logic rst, input logic en, input logic rl, input logic rv,
                       input logic [7:0] d, input exp_t e);
    @(negedge hsci_pclk);
    hsci_rst  = rst;
    enable    = en;
    realign   = rl;
    raw_valid = rv;
    raw_data  = d;
    sb_q.push_back(e);
  endtask

  // Reset cycle (all outputs zero) followed by the IDLE->SEARCH cycle.
  task automatic reset_and_start();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0));
  endtask

  // Feed n cycles of constant data; lock is expected on accepted word lock_at,
  // aligned output (training byte) one cycle after every later accepted word.
  // The accepted word numbered glitch is replaced by 8'h00.
  task automatic feed(input int n, input logic [7:0] d, input int lock_at,
                      input logic [2:0] k, input bit toggle, input int glitch);
    int acc = 0;
    for (int i = 0; i < n; i++) begin
      logic       rv;
      logic       was;
      logic [7:0] w;
      rv  = toggle ? ((i % 2) == 0) : 1'b1;
      was = (acc >= lock_at);
      w   = d;
      if (rv) begin
        acc++;
        if (acc == glitch) w = 8'h00;
      end
      drive(1'b0, 1'b1, 1'b0, rv, w,
            mk(acc >= lock_at, rv && was, rv && was, 8'h5A, acc >= lock_at, k, 1'b0));
    end
  endtask

  initial begin
    hsci_rst  = 1'b1;
    enable    = 1'b0;
    realign   = 1'b0;
    raw_valid = 1'b0;
    raw_data  = 8'h00;
    repeat (2) @(negedge hsci_pclk);

    // 8'h4B = training byte rotated right by 3; first usable window is word 2.
    reset_and_start();
    feed(24, 8'h4B, 17, 3'd3, 1'b0, -1);

    // realign while locked: lock drops, offset holds until the next match.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h4B, mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0));
    // 8'hD2 is the training byte rotated right by five, so it aligns at offset 5.
    feed(22, 8'hD2, 17, 3'd5, 1'b0, -1);

    // Reset while locked with data flowing, then relock from scratch.
    reset_and_start();
    feed(20, 8'h4B, 17, 3'd3, 1'b0, -1);

    // Dropping enable clears lock but keeps the offset.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h4B, mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h4B, mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0));

    // Offset 0 with a zero word at 11: the bad byte is seen at word 12,
    // search restarts at word 13 and lock lands on word 28.
    reset_and_start();
    feed(34, 8'h5A, 28, 3'd0, 1'b0, 11);

    // raw_valid toggling: lock after 16 matches among valid words.
    reset_and_start();
    feed(44, 8'h4B, 17, 3'd3, 1'b1, -1);

    // No pattern ever: timeout on the 64th search cycle, sticky afterwards.
    reset_and_start();
    for (int i = 1; i <= 70; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF,
            mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, i >= 64));
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0));

    repeat (3) @(negedge hsci_pclk);
    check_val("scoreboard_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
